// File: rtl/data_mem_ctrl.sv
// Data-memory controller: turns MemRead/MemWrite into a single doubleword-aligned memory
// request with byte lanes. The optional ack timeout is enabled by defining DMEM_TIMEOUT_EN.
`ifndef WORD
`define WORD [63:0]
`endif

module data_mem_ctrl #(
  parameter int TO_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       MemRead,
  input  logic       MemWrite,
  input  logic [1:0] size,
  input  logic `WORD addr,
  input  logic `WORD w_data,
  output logic `WORD r_data,
  output logic       stall,
  output logic       err,
  output logic       mem_req,
  output logic       mem_we,
  output logic `WORD mem_addr,
  output logic [7:0] mem_be,
  output logic `WORD mem_wdata,
  input  logic       mem_ack,
  input  logic `WORD mem_rdata
);

  // The wait counter is 8 bits wide, so the limit must fit in it.
  if (TO_LIMIT < 1 || TO_LIMIT > 255) begin : g_bad_limit
    $error("data_mem_ctrl: TO_LIMIT must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;

  logic [1:0]  size_q;
  logic [2:0]  off_q;
  logic        req;
  logic        misaligned;
  logic [7:0]  lane_mask;
  logic [63:0] rd_mask;
`ifdef DMEM_TIMEOUT_EN
  logic [7:0]  wait_cnt;
`endif

  assign req = MemRead | MemWrite;

  always_comb begin
    misaligned = 1'b0;
    lane_mask  = 8'h01;
    case (size)
      2'd0: begin lane_mask = 8'h01; misaligned = 1'b0;           end
      2'd1: begin lane_mask = 8'h03; misaligned = addr[0];        end
      2'd2: begin lane_mask = 8'h0F; misaligned = |addr[1:0];     end
      default: begin lane_mask = 8'hFF; misaligned = |addr[2:0];  end
    endcase
  end

  always_comb begin
    rd_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    case (size_q)
      2'd0:    rd_mask = 64'h0000_0000_0000_00FF;
      2'd1:    rd_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    rd_mask = 64'h0000_0000_FFFF_FFFF;
      default: rd_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  end

  // Stall covers the request cycle and every ACCESS cycle; RESP releases the datapath.
  assign stall = (state == ACCESS) || ((state == IDLE) && req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      r_data    <= '0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      size_q    <= '0;
      off_q     <= '0;
`ifdef DMEM_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (misaligned) begin
              state  <= RESP;
              err    <= 1'b1;
              r_data <= '0;
            end else begin
              state     <= ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= MemWrite;
              mem_addr  <= {addr[63:3], 3'b000};
              mem_be    <= lane_mask << addr[2:0];
              mem_wdata <= w_data << {addr[2:0], 3'b000};
              size_q    <= size;
              off_q     <= addr[2:0];
`ifdef DMEM_TIMEOUT_EN
              wait_cnt  <= '0;
`endif
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (!mem_we)
              r_data <= (mem_rdata >> {off_q, 3'b000}) & rd_mask;
          end
`ifdef DMEM_TIMEOUT_EN
          else if ({1'b0, wait_cnt} + 9'd1 == 9'(TO_LIMIT)) begin
            mem_req <= 1'b0;
            state   <= RESP;
            r_data  <= '0;
            err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: loads, stores, misalignment, reset mid-access and,
// when DMEM_TIMEOUT_EN is defined, the ack timeout (instance uses TO_LIMIT=4).
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  size;
  logic [63:0] addr;
  logic [63:0] w_data;
  logic [63:0] r_data;
  logic        stall;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  int vectors;
  int errors;

  data_mem_ctrl #(.TO_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .size(size),
    .addr(addr), .w_data(w_data), .r_data(r_data), .stall(stall), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [63:0] a, input logic [63:0] wd);
    MemRead = rd; MemWrite = wr; size = sz; addr = a; w_data = wd;
  endtask

  initial begin
    vectors = 0; errors = 0;
    rst_n = 1'b0; MemRead = 0; MemWrite = 0; size = 0; addr = 0; w_data = 0;
    mem_ack = 0; mem_rdata = 0;

    // Reset state
    tick(); tick();
    check("rst_r_data", r_data, 64'h0);
    check("rst_err", {63'b0, err}, 64'h0);
    check("rst_mem_req", {63'b0, mem_req}, 64'h0);
    check("rst_mem_we", {63'b0, mem_we}, 64'h0);
    check("rst_mem_be", {56'b0, mem_be}, 64'h0);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_mem_wdata", mem_wdata, 64'h0);
    check("rst_stall", {63'b0, stall}, 64'h0);
    rst_n = 1'b1;
    tick();

    // Dword read at 0x40, ack in the third ACCESS cycle
    issue(1, 0, 2'd3, 64'h40, 64'h0);
    #1 check("dw_req_stall", {63'b0, stall}, 64'h1);
    tick();
    issue(0, 0, 2'd0, 64'h0, 64'h0);
    check("dw_mem_req", {63'b0, mem_req}, 64'h1);
    check("dw_mem_be", {56'b0, mem_be}, 64'hFF);
    check("dw_mem_addr", mem_addr, 64'h40);
    check("dw_mem_we", {63'b0, mem_we}, 64'h0);
    check("dw_stall_acc1", {63'b0, stall}, 64'h1);
    tick();
    check("dw_mem_req_acc2", {63'b0, mem_req}, 64'h1);
    check("dw_stall_acc2", {63'b0, stall}, 64'h1);
    tick();
    check("dw_mem_req_acc3", {63'b0, mem_req}, 64'h1);
    mem_ack = 1; mem_rdata = 64'h1122334455667788;
    tick();
    // RESP: stray ack here must be ignored
    mem_ack = 1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
    check("dw_r_data", r_data, 64'h1122334455667788);
    check("dw_resp_stall", {63'b0, stall}, 64'h0);
    check("dw_resp_req", {63'b0, mem_req}, 64'h0);
    check("dw_resp_err", {63'b0, err}, 64'h0);
    tick();
    mem_ack = 0;
    check("dw_stray_ack_r_data", r_data, 64'h1122334455667788);
    check("dw_idle_req", {63'b0, mem_req}, 64'h0);
    tick();
    check("dw_stray_ack2_r_data", r_data, 64'h1122334455667788);

    // Byte store at 0x45
    issue(0, 1, 2'd0, 64'h45, 64'hAB);
    #1 check("bs_req_stall", {63'b0, stall}, 64'h1);
    tick();
    issue(0, 0, 2'd0, 64'h0, 64'h0);
    check("bs_mem_addr", mem_addr, 64'h40);
    check("bs_mem_be", {56'b0, mem_be}, 64'h20);
    check("bs_mem_wdata", mem_wdata, 64'h0000AB0000000000);
    check("bs_mem_we", {63'b0, mem_we}, 64'h1);
    check("bs_mem_req", {63'b0, mem_req}, 64'h1);
    mem_ack = 1; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    mem_ack = 0;
    check("bs_r_data_kept", r_data, 64'h1122334455667788);
    check("bs_resp_stall", {63'b0, stall}, 64'h0);
    tick();

    // Half load at 0x12, ack in first ACCESS cycle
    issue(1, 0, 2'd1, 64'h12, 64'h0);
    #1 check("hl_req_stall", {63'b0, stall}, 64'h1);
    tick();
    issue(0, 0, 2'd0, 64'h0, 64'h0);
    check("hl_mem_addr", mem_addr, 64'h10);
    check("hl_mem_be", {56'b0, mem_be}, 64'h0C);
    check("hl_stall_acc", {63'b0, stall}, 64'h1);
    mem_ack = 1; mem_rdata = 64'hDEADBEEFCAFE0000;
    tick();
    mem_ack = 0;
    check("hl_r_data", r_data, 64'h000000000000CAFE);
    check("hl_resp_stall", {63'b0, stall}, 64'h0);
    tick();

    // Misaligned word at 0x42
    issue(1, 0, 2'd2, 64'h42, 64'h0);
    #1 check("mw_req_stall", {63'b0, stall}, 64'h1);
    tick();
    issue(0, 0, 2'd0, 64'h0, 64'h0);
    check("mw_err", {63'b0, err}, 64'h1);
    check("mw_r_data", r_data, 64'h0);
    check("mw_mem_req", {63'b0, mem_req}, 64'h0);
    check("mw_resp_stall", {63'b0, stall}, 64'h0);
    tick();
    check("mw_err_pulse", {63'b0, err}, 64'h0);
    check("mw_mem_req_after", {63'b0, mem_req}, 64'h0);

    // Read+write priority, then reset during ACCESS
    issue(1, 1, 2'd3, 64'h48, 64'h55);
    tick();
    issue(0, 0, 2'd0, 64'h0, 64'h0);
    check("rw_mem_we", {63'b0, mem_we}, 64'h1);
    check("rw_mem_req", {63'b0, mem_req}, 64'h1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_req", {63'b0, mem_req}, 64'h0);
    tick();
    rst_n = 1'b1;
    mem_ack = 1; mem_rdata = 64'h7777_7777_7777_7777;
    tick();
    mem_ack = 0;
    check("rst_late_ack_req", {63'b0, mem_req}, 64'h0);
    check("rst_late_ack_stall", {63'b0, stall}, 64'h0);
    check("rst_late_ack_r_data", r_data, 64'h0);

    // Byte load at 0x47 after reset
    issue(1, 0, 2'd0, 64'h47, 64'h0);
    #1 check("bl_req_stall", {63'b0, stall}, 64'h1);
    tick();
    issue(0, 0, 2'd0, 64'h0, 64'h0);
    check("bl_mem_be", {56'b0, mem_be}, 64'h80);
    check("bl_mem_req", {63'b0, mem_req}, 64'h1);
    mem_ack = 1; mem_rdata = 64'hA500_0000_0000_0012;
    tick();
    mem_ack = 0;
    check("bl_r_data", r_data, 64'hA5);
    tick();

    // Word load at 0x50, ack withheld
    issue(1, 0, 2'd2, 64'h50, 64'h0);
    tick();
    issue(0, 0, 2'd0, 64'h0, 64'h0);
    check("to_acc1_req", {63'b0, mem_req}, 64'h1);
    tick();
    tick();
    tick();
    check("to_acc4_req", {63'b0, mem_req}, 64'h1);
    check("to_acc4_err", {63'b0, err}, 64'h0);
    tick();
`ifdef DMEM_TIMEOUT_EN
    check("to_req_dropped", {63'b0, mem_req}, 64'h0);
    check("to_err", {63'b0, err}, 64'h1);
    check("to_r_data", r_data, 64'h0);
    check("to_resp_stall", {63'b0, stall}, 64'h0);
    tick();
    check("to_err_pulse", {63'b0, err}, 64'h0);
`else
    tick(); tick();
    check("wait_req_held", {63'b0, mem_req}, 64'h1);
    check("wait_stall_held", {63'b0, stall}, 64'h1);
    check("wait_no_err", {63'b0, err}, 64'h0);
    mem_ack = 1; mem_rdata = 64'h0000_0000_0BAD_F00D;
    tick();
    mem_ack = 0;
    check("wait_r_data", r_data, 64'h0BADF00D);
    check("wait_resp_stall", {63'b0, stall}, 64'h0);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have one parameter: TO_LIMIT, default 255, the maximum number of wait cycles for mem_ack (used only with DMEM_TIMEOUT_EN).
REQ-002 The block SHALL use one clock, clk; reset is rst_n, asynchronous and active-low.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- MemRead  in  1  load request from the control unit
- MemWrite  in  1  store request from the control unit
- size  in  2  access size: 0=byte, 1=half, 2=word, 3=dword
- addr  in  `WORD  byte address, taken from the datapath ALUOut
- w_data  in  `WORD  store data, taken from the datapath MemData (right-aligned)
- r_data  out  `WORD  load data, zero-extended, to the datapath
- stall  out  1  freezes PC/register writes while high
- err  out  1  one-cycle pulse: misaligned access or timeout
- mem_req  out  1  memory request; held until ack
- mem_we  out  1  1=write, 0=read
- mem_addr  out  `WORD  {addr[63:3],3'b000}
- mem_be  out  8  byte-lane enables
- mem_wdata  out  `WORD  lane-shifted store data
- mem_ack  in  1  memory completion, one cycle
- mem_rdata  in  `WORD  read doubleword, valid with mem_ack

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-005 In IDLE, stall SHALL be asserted combinationally whenever MemRead or MemWrite is high.
REQ-006 On a clk edge in IDLE with a request, the block SHALL register addr, size, w_data and the direction, then go to ACCESS (aligned) or RESP (misaligned).
REQ-007 MemWrite SHALL take priority over MemRead when both are high.
REQ-008 Alignment SHALL be: byte always aligned; half needs addr[0]=0; word needs addr[1:0]=0; dword needs addr[2:0]=0.
REQ-009 In ACCESS, mem_req SHALL be 1 and mem_addr/mem_be/mem_wdata/mem_we SHALL hold stable until the cycle mem_ack=1; then the FSM SHALL go to RESP.
REQ-010 mem_be SHALL be the size mask (0x01, 0x03, 0x0F, 0xFF) shifted left by addr[2:0]; mem_wdata SHALL be w_data shifted left by 8*addr[2:0].
REQ-011 On mem_ack for a read, the block SHALL register mem_rdata >> (8*addr[2:0]), masked to size and zero-extended, into r_data.
REQ-012 In RESP, stall SHALL be 0 for exactly one cycle so the datapath retires the instruction, and the FSM SHALL then return to IDLE unconditionally.
REQ-013 A misaligned access SHALL issue no mem_req, SHALL reach RESP in one cycle with r_data=0, and SHALL pulse err=1 in the RESP cycle.
REQ-014 Minimum latency SHALL be request cycle + 1 ACCESS cycle (ack in first ACCESS cycle) + RESP, giving 2 stalled cycles.
REQ-015 r_data SHALL hold its last load value except when overwritten by a load or a misaligned/timeout response; stores SHALL NOT change it.
REQ-016 mem_ack outside ACCESS SHALL be ignored.

Reset
REQ-017 While rst_n=0, the FSM SHALL be in IDLE with r_data=0, err=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0 and mem_wdata=0.
REQ-018 Reset asserted mid-ACCESS SHALL drop mem_req immediately (asynchronously); a later mem_ack SHALL be ignored.

Configuration
REQ-019 With DMEM_TIMEOUT_EN defined, an 8-bit wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ack.
REQ-020 Under DMEM_TIMEOUT_EN, when the count reaches TO_LIMIT, the block SHALL drop mem_req, go to RESP, set r_data=0 and pulse err.
REQ-021 Without DMEM_TIMEOUT_EN, no counter SHALL be instantiated and ACCESS SHALL wait indefinitely.

Verification
REQ-022 Dword read: MemRead=1, size=3, addr=0x40, ack after 3 cycles with rdata=0x1122334455667788 -> mem_be=0xFF, r_data=0x1122334455667788 in RESP, stall low exactly 1 cycle.
REQ-023 Byte store: MemWrite=1, size=0, addr=0x45, w_data=0xAB -> mem_addr=0x40, mem_be=0x20, mem_wdata=0x0000AB0000000000, mem_we=1.
REQ-024 Half load: addr=0x12, size=1, rdata=0xDEADBEEFCAFE0000 -> r_data=0x000000000000CAFE.
REQ-025 Misaligned word: size=2, addr=0x42 -> no mem_req, err=1 for 1 cycle, r_data=0, 1 stalled cycle.
REQ-026 MemRead=MemWrite=1 -> mem_we=1; assert rst_n=0 during ACCESS -> mem_req=0 in the same cycle, FSM in IDLE after release.
REQ-027 With DMEM_TIMEOUT_EN and TO_LIMIT=4, never ack -> mem_req drops after 4 ACCESS cycles, err pulse, r_data=0.
